mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Round-robin arbiter for the shared tri-state memory data bus. It accepts requests from up to `NUM_MASTERS` bus masters and grants ownership to one at a time. It produces the one-hot drive enables that feed each master's tri-state buffer `control` input. A mandatory one-cycle turnaround between owners guarantees the bus is never driven by two masters in the same cycle.

## Interface
- `NUM_MASTERS`, default 4: number of requesters. Legal range 2..8.
- `TIMEOUT`, default 256: maximum number of OWN cycles per grant. Used only when the timeout feature is compiled in. Legal range 2..65535.
- `IDX_W`, default `$clog2(NUM_MASTERS)`: owner index width. Derived; never overridden.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_MASTERS  per-master request. A master holds its bit high for the whole ownership.
- `gnt`  out  NUM_MASTERS  one-hot grant, registered.
- `drv_en`  out  NUM_MASTERS  one-hot tri-state drive enable, registered. Wired to each master's buffer `control`.
- `busy`  out  1  high while any master owns the bus.
- `owner`  out  IDX_W  index of the current owner. Valid only while `busy`=1; holds its last value otherwise.
- `timeout`  out  1  one-cycle pulse when a grant is forcibly revoked. Tied 0 when the timeout feature is compiled out.

## Operation
- States: IDLE, OWN, TURN.
- IDLE:
  - If any `req` bit is 1, select a winner by round-robin and go to OWN.
  - Otherwise remain in IDLE.
- OWN:
  - `gnt[owner]`, `drv_en[owner]` and `busy` are all 1.
  - If `req[owner]` is 0 at the edge, go to TURN and update the priority pointer `ptr <= owner`.
  - Requests from other masters are ignored while in OWN.
- TURN:
  - All of `gnt`, `drv_en` and `busy` are 0; the bus floats for exactly one cycle.
  - At the end of TURN, arbitrate over `req`. Go to OWN with the new winner if any bit is set, otherwise go to IDLE.
  - A master that releases and re-requests is eligible again at the end of TURN.
- Round-robin rule:
  - Search starts at `(ptr+1) mod NUM_MASTERS` and takes the first set bit.
  - `ptr` resets to `NUM_MASTERS-1`, so master 0 has first priority after reset.
  - Winner-index arithmetic wraps modulo `NUM_MASTERS`; index `NUM_MASTERS-1` wraps to 0. This holds for non-power-of-two counts.
- Invariants:
  - At most one bit of `gnt` is set.
  - `drv_en` equals `gnt` in every cycle.
  - No two consecutive cycles have different masters' `drv_en` set.
- Reset: `rst_n`=0 forces IDLE immediately, without waiting for `clk`. Reset values:
  - `gnt`=0, `drv_en`=0, `busy`=0, `owner`=0, `timeout`=0.
  - `ptr`=`NUM_MASTERS-1`; timeout counter=0.
- Reset asserted mid-OWN must drop `drv_en` asynchronously, so no stale driver remains.

## Timing
- Grant latency: a `req` sampled high at edge k while in IDLE gives `gnt`/`drv_en` high from edge k onward, visible in cycle k+1.
- Release latency: `req[owner]` sampled low at edge k gives `gnt`/`drv_en` low in cycle k+1 (TURN).
- Handoff gap: exactly one bus-idle cycle between consecutive owners, never zero and never more than one when another request is pending.
- All outputs come directly from flops; there is no combinational path from `req` to any output.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to OWN and increments each OWN cycle.
  - When the count reaches `TIMEOUT-1` with `req[owner]` still 1, the arbiter goes to TURN regardless of `req`, sets `ptr <= owner`, and pulses `timeout` for the first TURN cycle.
  - The revoked master may be regranted later under normal round-robin.
- `MEM_ARB_TIMEOUT_EN` undefined:
  - No counter is built; ownership lasts until `req[owner]` drops.
  - `timeout` is a constant 0.

## Test plan
- Reset: hold `rst_n`=0 with `req`=4'b1111 → all outputs 0. Release reset → `gnt`=4'b0001 one cycle after the first sampling edge.
- Single master: raise `req`=4'b0100 at edge 1 → `gnt`=`drv_en`=4'b0100, `owner`=2 from cycle 2. Drop req at edge 5 → outputs 0 in cycle 6 (TURN), IDLE in cycle 7.
- Full contention: `req`=4'b1111 held, each owner drops its req after 3 OWN cycles → grant order 0,1,2,3, with exactly one all-zero cycle between each owner.
- Rotation: master 1 owns while masters 0 and 3 request; master 1 releases → next owner is 3, then 0.
- Timeout (`MEM_ARB_TIMEOUT_EN`, `TIMEOUT`=8): master 0 holds req, master 1 requests → `drv_en[0]` falls after 8 OWN cycles, `timeout`=1 for one cycle, then `gnt`=4'b0010.
- Async reset: assert `rst_n`=0 mid-cycle during OWN → `drv_en`/`gnt` go to 0 before the next `clk` edge; operation resumes from IDLE with master 0 highest priority.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Round-robin owner arbiter for a shared tri-state data bus, with a one-cycle turnaround between owners.
// Optional forced-release watchdog compiled in with `define MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int TIMEOUT     = 256,
   parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_MASTERS-1:0] req,
   output logic [NUM_MASTERS-1:0] gnt,
   output logic [NUM_MASTERS-1:0] drv_en,
   output logic                   busy,
   output logic [IDX_W-1:0]       owner,
   output logic                   timeout
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_OWN,
      ST_TURN
   } state_t;

   if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_num
      $error("mem_bus_arbiter: NUM_MASTERS out of range 2..8");
   end
   if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("mem_bus_arbiter: TIMEOUT out of range 2..65535");
   end

   state_t                 state_q, state_d;
   logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
   logic [NUM_MASTERS-1:0] drv_en_q, drv_en_d;
   logic                   busy_q, busy_d;
   logic [IDX_W-1:0]       owner_q, owner_d;
   logic [IDX_W-1:0]       ptr_q, ptr_d;
   logic                   found;
   logic [IDX_W-1:0]       winner;
   logic                   force_rel;

   // First set request searching upward from ptr+1, wrapping modulo NUM_MASTERS.
   always_comb begin
      logic [IDX_W-1:0] idx;
      found  = 1'b0;
      winner = '0;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         idx = IDX_W'((int'(ptr_q) + i) % NUM_MASTERS);
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

`ifdef MEM_ARB_TIMEOUT_EN
   logic [15:0] cnt_q, cnt_d;
   logic        timeout_q, timeout_d;

   assign force_rel = (cnt_q == 16'(TIMEOUT - 1));
   assign timeout   = timeout_q;
`else
   assign force_rel = 1'b0;
   assign timeout   = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      drv_en_d = drv_en_q;
      busy_d   = busy_q;
      owner_d  = owner_q;
      ptr_d    = ptr_q;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
`endif
      case (state_q)
         ST_IDLE, ST_TURN: begin
            if (found) begin
               state_d  = ST_OWN;
               gnt_d    = NUM_MASTERS'(1) << winner;
               drv_en_d = NUM_MASTERS'(1) << winner;
               busy_d   = 1'b1;
               owner_d  = winner;
`ifdef MEM_ARB_TIMEOUT_EN
               cnt_d    = '0;
`endif
            end else begin
               state_d  = ST_IDLE;
               gnt_d    = '0;
               drv_en_d = '0;
               busy_d   = 1'b0;
            end
         end
         ST_OWN: begin
            // A voluntary release and a forced one both pass through TURN.
            if (!req[owner_q] || force_rel) begin
               state_d  = ST_TURN;
               gnt_d    = '0;
               drv_en_d = '0;
               busy_d   = 1'b0;
               ptr_d    = owner_q;
`ifdef MEM_ARB_TIMEOUT_EN
               timeout_d = req[owner_q];
`endif
            end else begin
`ifdef MEM_ARB_TIMEOUT_EN
               cnt_d = cnt_q + 16'd1;
`endif
            end
         end
         default: begin
            state_d  = ST_IDLE;
            gnt_d    = '0;
            drv_en_d = '0;
            busy_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         gnt_q     <= '0;
         drv_en_q  <= '0;
         busy_q    <= 1'b0;
         owner_q   <= '0;
         ptr_q     <= IDX_W'(NUM_MASTERS - 1);
`ifdef MEM_ARB_TIMEOUT_EN
         cnt_q     <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         drv_en_q  <= drv_en_d;
         busy_q    <= busy_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
`ifdef MEM_ARB_TIMEOUT_EN
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   assign gnt    = gnt_q;
   assign drv_en = drv_en_q;
   assign busy   = busy_q;
   assign owner  = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: per-cycle vector table plus reset and watchdog sequences.
module tb_mem_bus_arbiter;

   localparam int N = 4;
`ifdef MEM_ARB_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 256;
`endif

   logic         clk;
   logic         rst_n;
   logic [N-1:0] req;
   logic [N-1:0] gnt;
   logic [N-1:0] drv_en;
   logic         busy;
   logic [1:0]   owner;
   logic         timeout;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   logic [N-1:0] prev_drv;

   typedef struct {
      logic [N-1:0] req;
      logic [N-1:0] gnt;
      logic         busy;
      logic [1:0]   owner;
   } vec_t;

   vec_t vecs[$];

   mem_bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TO)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req),
      .gnt    (gnt),
      .drv_en (drv_en),
      .busy   (busy),
      .owner  (owner),
      .timeout(timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic add(input logic [N-1:0] r, input logic [N-1:0] g, input logic b, input logic [1:0] o);
      vec_t v;
      v.req = r; v.gnt = g; v.busy = b; v.owner = o;
      vecs.push_back(v);
   endtask

   task automatic check_outs(input string tag, input logic [N-1:0] g, input logic b,
                             input logic [1:0] o, input logic t);
      check({tag, ".gnt"}, 32'(gnt), 32'(g));
      check({tag, ".drv_en"}, 32'(drv_en), 32'(g));
      check({tag, ".busy"}, 32'(busy), 32'(b));
      check({tag, ".owner"}, 32'(owner), 32'(o));
      check({tag, ".timeout"}, 32'(timeout), 32'(t));
   endtask

   task automatic apply(input int k, input vec_t v);
      string tag;
      @(negedge clk);
      req = v.req;
      @(posedge clk);
      #1;
      tag = $sformatf("vec%0d", k);
      check_outs(tag, v.gnt, v.busy, v.owner, 1'b0);
      check({tag, ".onehot"}, 32'($countones(gnt) <= 1), 32'(1));
      check({tag, ".handoff"}, 32'(prev_drv == '0 || drv_en == '0 || prev_drv == drv_en), 32'(1));
      prev_drv = drv_en;
      $display("vec %0d: req=%b gnt=%b drv_en=%b busy=%b owner=%0d", k, v.req, gnt, drv_en, busy, owner);
   endtask

   initial begin
      // full contention, each owner holds three cycles
      for (int m = 0; m < N; m++) begin
         logic [N-1:0] g;
         logic [N-1:0] drop;
         g = N'(1) << m;
         drop = 4'b1111 & ~g;
         for (int c = 0; c < 3; c++) add(4'b1111, g, 1'b1, 2'(m));
         add(drop, 4'b0000, 1'b0, 2'(m));
      end
      add(4'b0000, 4'b0000, 1'b0, 2'd3);
      // single master
      add(4'b0100, 4'b0100, 1'b1, 2'd2);
      add(4'b0100, 4'b0100, 1'b1, 2'd2);
      add(4'b0100, 4'b0100, 1'b1, 2'd2);
      add(4'b0000, 4'b0000, 1'b0, 2'd2);
      add(4'b0000, 4'b0000, 1'b0, 2'd2);
      // rotation: 1 owns, 0 and 3 waiting -> 3 then 0
      add(4'b0010, 4'b0010, 1'b1, 2'd1);
      add(4'b1011, 4'b0010, 1'b1, 2'd1);
      add(4'b1001, 4'b0000, 1'b0, 2'd1);
      add(4'b1001, 4'b1000, 1'b1, 2'd3);
      add(4'b0001, 4'b0000, 1'b0, 2'd3);
      add(4'b0001, 4'b0001, 1'b1, 2'd0);
      add(4'b0000, 4'b0000, 1'b0, 2'd0);
      add(4'b0000, 4'b0000, 1'b0, 2'd0);
      // release then re-request during TURN: regranted at end of TURN
      add(4'b0100, 4'b0100, 1'b1, 2'd2);
      add(4'b0000, 4'b0000, 1'b0, 2'd2);
      add(4'b0100, 4'b0100, 1'b1, 2'd2);
      add(4'b0000, 4'b0000, 1'b0, 2'd2);
      add(4'b0000, 4'b0000, 1'b0, 2'd2);

      // reset held with all requests pending
      rst_n = 1'b0;
      req   = 4'b1111;
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
      $display("reset: gnt=%b drv_en=%b busy=%b owner=%0d", gnt, drv_en, busy, owner);
      @(negedge clk);
      rst_n = 1'b1;
      req   = 4'b0000;

      prev_drv = '0;
      foreach (vecs[i]) apply(i, vecs[i]);

      // async reset mid-OWN: drivers drop before the next clock edge
      @(negedge clk);
      req = 4'b0100;
      @(posedge clk);
      #1;
      check("arst.pre_gnt", 32'(gnt), 32'(4'b0100));
      #2;
      rst_n = 1'b0;
      #1;
      check_outs("arst.async", 4'b0000, 1'b0, 2'd0, 1'b0);
      $display("async reset: gnt=%b drv_en=%b busy=%b", gnt, drv_en, busy);
      req = 4'b1111;
      @(posedge clk);
      #1;
      check_outs("arst.held", 4'b0000, 1'b0, 2'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_outs("arst.resume", 4'b0001, 1'b1, 2'd0, 1'b0);
      $display("resume: gnt=%b owner=%0d", gnt, owner);

`ifdef MEM_ARB_TIMEOUT_EN
      // watchdog: master 0 holds, master 1 waits
      @(negedge clk);
      rst_n = 1'b0;
      req   = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      req = 4'b0011;
      for (int c = 1; c <= TO; c++) begin
         @(posedge clk);
         #1;
         check_outs($sformatf("wdog.own%0d", c), 4'b0001, 1'b1, 2'd0, 1'b0);
      end
      @(posedge clk);
      #1;
      check_outs("wdog.turn", 4'b0000, 1'b0, 2'd0, 1'b1);
      $display("watchdog turn: gnt=%b timeout=%b", gnt, timeout);
      @(posedge clk);
      #1;
      check_outs("wdog.next", 4'b0010, 1'b1, 2'd1, 1'b0);
      $display("watchdog next: gnt=%b owner=%0d timeout=%b", gnt, owner, timeout);
`endif

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
